// File: rtl/mem_access_ctrl_if.sv
// ----------------------------------------------------------------------------
// mem_access_ctrl_if
// Groups the signals around the MEM-stage memory access controller. The
// pipeline side (EX/MEM register) and the data-memory side are carried together.
//
// Handshake:
//   * The pipeline presents memRead_MEM / memWrite_MEM with ALU_result_MEM and
//     st_value_MEM, and holds them while stall=1. The instruction leaves
//     EX/MEM on the first rising edge that sees stall=0.
//   * The controller holds mem_rd / mem_wr / mem_addr / mem_wdata stable until
//     the memory answers with a one-cycle mem_done. mem_rdata is valid only
//     while mem_done=1.
//
// Modports:
//   slave  - view of the controller itself.
//   master - view of the surrounding pipeline/memory (testbench side).
// ----------------------------------------------------------------------------
interface mem_access_ctrl_if;
  // pipeline -> controller
  logic [15:0] ALU_result_MEM;
  logic [15:0] st_value_MEM;
  logic        memRead_MEM;
  logic        memWrite_MEM;
  // memory -> controller
  logic        mem_done;
  logic [15:0] mem_rdata;
  // controller -> memory
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  // controller -> pipeline
  logic        stall;
  logic [15:0] readData_MEM;
  logic        err;

  modport slave (
    input  ALU_result_MEM, st_value_MEM, memRead_MEM, memWrite_MEM,
    input  mem_done, mem_rdata,
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    output stall, readData_MEM, err
  );

  modport master (
    output ALU_result_MEM, st_value_MEM, memRead_MEM, memWrite_MEM,
    output mem_done, mem_rdata,
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    input  stall, readData_MEM, err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// ----------------------------------------------------------------------------
// mem_access_ctrl
// MEM-stage data-memory access controller. Turns a load/store held in the
// EX/MEM register into a registered memory request, stalls the pipeline until
// the memory completes (or a 16-cycle timeout expires), then releases the
// pipeline for exactly one cycle so the instruction leaves without re-issue.
//
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous active-low reset
//   bus          - mem_access_ctrl_if.slave (pipeline + memory signals)
//   o_dbg_state  - current FSM state (IDLE=0, BUSY=1, DONE=2)
// ----------------------------------------------------------------------------
module mem_access_ctrl (
  input  logic                  clk,
  input  logic                  rst,
  mem_access_ctrl_if.slave      bus,
  output logic [1:0]            o_dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_mem_rd;
  logic        r_mem_wr;
  logic [15:0] r_mem_addr;
  logic [15:0] r_mem_wdata;
  logic [15:0] r_read_data;
  logic        r_err;

  logic        w_access;
  logic        w_illegal;
  logic        w_stall;

  assign w_access  = bus.memRead_MEM | bus.memWrite_MEM;
  // Simultaneous load+store or an odd (non-halfword-aligned) address.
  assign w_illegal = w_access &
                     ((bus.memRead_MEM & bus.memWrite_MEM) | bus.ALU_result_MEM[0]);

  // Stall is combinational so the EX/MEM register holds in the very cycle an
  // access is first seen. Gated by rst so it is low throughout reset.
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      S_IDLE:  w_stall = w_access;
      S_BUSY:  w_stall = 1'b1;
      S_DONE:  w_stall = 1'b0;
      default: w_stall = 1'b0;
    endcase
    w_stall = w_stall & rst;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= 16'h0000;
      r_mem_wdata <= 16'h0000;
      r_read_data <= 16'h0000;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            if (w_illegal) begin
              // No request issued; DONE releases the offending instruction.
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_mem_addr  <= bus.ALU_result_MEM;
              r_mem_wdata <= bus.st_value_MEM;
              r_mem_rd    <= bus.memRead_MEM;
              r_mem_wr    <= bus.memWrite_MEM;
              r_cnt       <= 4'd0;
              r_state     <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (bus.mem_done) begin
            if (r_mem_rd) r_read_data <= bus.mem_rdata;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_state  <= S_DONE;
          end else if (r_cnt == 4'hF) begin
            // 16th consecutive BUSY cycle without completion.
            r_err       <= 1'b1;
            r_read_data <= 16'h0000;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_wdata    = r_mem_wdata;
  assign bus.mem_rd       = r_mem_rd;
  assign bus.mem_wr       = r_mem_wr;
  assign bus.stall        = w_stall;
  assign bus.readData_MEM = r_read_data;
  assign bus.err          = r_err;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed vectors with hand-computed expectations. Each access pushes its
// expected outcome record into exp_q; a monitor on the falling edge measures
// each stall window and pops/compares when the pipeline is released.
// ----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  mem_access_ctrl_if bus();

  mem_access_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // {stall_cycles[8], rd_cycles[8], wr_cycles[8], addr[16], wdata[16], rdata[16], err[1]}
  localparam int W = 73;
  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int st, input int rd, input int wr,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] rdata, input logic err);
    logic [7:0] s8, r8, w8;
    s8 = st[7:0]; r8 = rd[7:0]; w8 = wr[7:0];
    exp_q.push_back({s8, r8, w8, addr, wdata, rdata, err});
  endtask

  // ---------------- monitor ----------------
  int          m_stall, m_rd, m_wr;
  logic [15:0] m_addr, m_wdata;
  logic        prev_stall = 1'b0;
  logic [W-1:0] e;

  always @(negedge clk) begin
    if (!rst) begin
      m_stall = 0; m_rd = 0; m_wr = 0; m_addr = 0; m_wdata = 0;
      prev_stall = 1'b0;
    end else begin
      if (bus.stall) begin
        if (!prev_stall) begin
          m_stall = 0; m_rd = 0; m_wr = 0; m_addr = 0; m_wdata = 0;
        end
        m_stall++;
        if (bus.mem_rd) m_rd++;
        if (bus.mem_wr) m_wr++;
        if (bus.mem_rd | bus.mem_wr) begin
          m_addr  = bus.mem_addr;
          m_wdata = bus.mem_wdata;
        end
      end else if (prev_stall) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_release: got release expected none");
        end else begin
          e = exp_q.pop_front();
          check1("stall_cycles", m_stall,          {24'd0, e[72:65]});
          check1("rd_cycles",    m_rd,             {24'd0, e[64:57]});
          check1("wr_cycles",    m_wr,             {24'd0, e[56:49]});
          check1("mem_addr",     {16'd0, m_addr},  {16'd0, e[48:33]});
          check1("mem_wdata",    {16'd0, m_wdata}, {16'd0, e[32:17]});
          check1("readData",     {16'd0, bus.readData_MEM}, {16'd0, e[16:1]});
          check1("err",          {31'd0, bus.err}, {31'd0, e[0]});
        end
      end
      prev_stall = bus.stall;
    end
  end

  // ---------------- driver ----------------
  // Presents one access, answers with mem_done in BUSY cycle 'lat' (0 = never),
  // keeps the request held while stalled, then retires it after release.
  task automatic drive(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wdata, input int lat, input logic [15:0] rdata);
    int k;
    bit released;
    k = 0;
    released = 1'b0;
    bus.memRead_MEM    = rd;
    bus.memWrite_MEM   = wr;
    bus.ALU_result_MEM = addr;
    bus.st_value_MEM   = wdata;
    bus.mem_done       = 1'b0;
    for (int g = 0; g < 40; g++) begin
      @(negedge clk);
      if (!bus.stall) begin
        released = 1'b1;
        break;
      end
      @(posedge clk); #1;
      k++;
      bus.mem_done  = (k == lat);
      bus.mem_rdata = (k == lat) ? rdata : 16'hDEAD;
    end
    if (!released) begin
      checks++;
      errors++;
      $display("FAIL release_timeout: got stall=1 after 40 cycles expected 0");
    end
    @(posedge clk); #1;
    bus.memRead_MEM  = 1'b0;
    bus.memWrite_MEM = 1'b0;
    bus.mem_done     = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    bus.ALU_result_MEM = 16'h0000;
    bus.st_value_MEM   = 16'h0000;
    bus.memRead_MEM    = 1'b1;   // access present during reset: stall must stay low
    bus.memWrite_MEM   = 1'b0;
    bus.mem_done       = 1'b0;
    bus.mem_rdata      = 16'h0000;
    #12;
    check1("rst_stall",    {31'd0, bus.stall},        32'd0);
    check1("rst_mem_rd",   {31'd0, bus.mem_rd},       32'd0);
    check1("rst_mem_wr",   {31'd0, bus.mem_wr},       32'd0);
    check1("rst_mem_addr", {16'd0, bus.mem_addr},     32'd0);
    check1("rst_wdata",    {16'd0, bus.mem_wdata},    32'd0);
    check1("rst_readData", {16'd0, bus.readData_MEM}, 32'd0);
    check1("rst_err",      {31'd0, bus.err},          32'd0);
    check1("rst_state",    {30'd0, dbg_state},        32'd0);
    bus.memRead_MEM = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // load, done in first BUSY cycle
    push_exp(2, 1, 0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
    drive(1'b1, 1'b0, 16'h0010, 16'h0000, 1, 16'hBEEF);
    // store, latency 3, readData unchanged
    push_exp(4, 0, 3, 16'h0020, 16'h1234, 16'hBEEF, 1'b0);
    drive(1'b0, 1'b1, 16'h0020, 16'h1234, 3, 16'hDEAD);
    // back-to-back load, latency 2
    push_exp(3, 2, 0, 16'h0040, 16'h0000, 16'h5A5A, 1'b0);
    drive(1'b1, 1'b0, 16'h0040, 16'h0000, 2, 16'h5A5A);
    // misaligned load
    push_exp(1, 0, 0, 16'h0000, 16'h0000, 16'h5A5A, 1'b1);
    drive(1'b1, 1'b0, 16'h0011, 16'h0000, 1, 16'h9999);
    // load and store together
    push_exp(1, 0, 0, 16'h0000, 16'h0000, 16'h5A5A, 1'b1);
    drive(1'b1, 1'b1, 16'h0030, 16'h7777, 1, 16'h9999);
    // stray mem_done in IDLE must be ignored
    bus.mem_done  = 1'b1;
    bus.mem_rdata = 16'h1111;
    @(posedge clk); #1;
    bus.mem_done  = 1'b0;
    // store after error: err stays sticky
    push_exp(2, 0, 1, 16'h0050, 16'hABCD, 16'h5A5A, 1'b1);
    drive(1'b0, 1'b1, 16'h0050, 16'hABCD, 1, 16'h2222);
    // timeout
    push_exp(17, 16, 0, 16'h0060, 16'h0000, 16'h0000, 1'b1);
    drive(1'b1, 1'b0, 16'h0060, 16'h0000, 0, 16'h0000);

    // reset in the 2nd BUSY cycle of a load
    bus.memRead_MEM    = 1'b1;
    bus.ALU_result_MEM = 16'h0004;
    bus.st_value_MEM   = 16'h0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check1("mid_busy_rd", {31'd0, bus.mem_rd}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check1("mid_rst_mem_rd",   {31'd0, bus.mem_rd},       32'd0);
    check1("mid_rst_stall",    {31'd0, bus.stall},        32'd0);
    check1("mid_rst_err",      {31'd0, bus.err},          32'd0);
    check1("mid_rst_readData", {16'd0, bus.readData_MEM}, 32'd0);
    check1("mid_rst_addr",     {16'd0, bus.mem_addr},     32'd0);
    bus.memRead_MEM = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    push_exp(2, 1, 0, 16'h0004, 16'h0000, 16'h7777, 1'b0);
    drive(1'b1, 1'b0, 16'h0004, 16'h0000, 1, 16'h7777);

    repeat (3) @(posedge clk);
    #1;
    check1("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  clock; all state updates on its rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 ALU_result_MEM  in  16  access address from the EX/MEM register.
REQ-005 st_value_MEM  in  16  store data from the EX/MEM register.
REQ-006 memRead_MEM, memWrite_MEM  in  1 each  load and store request from the EX/MEM register.
REQ-007 mem_done  in  1  data-memory completion strobe.
REQ-008 mem_rdata  in  16  data-memory read data, valid when mem_done=1.
REQ-009 mem_addr, mem_wdata  out  16 each  registered address and store data to the data memory.
REQ-010 mem_rd, mem_wr  out  1 each  registered memory read and write request.
REQ-011 stall  out  1  pipeline hold; drives the stall input of the EX/MEM register and of earlier stages.
REQ-012 readData_MEM  out  16  registered load result forwarded to MEM/WB.
REQ-013 err  out  1  sticky error flag.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, BUSY and DONE.
REQ-015 An access SHALL be defined as memRead_MEM | memWrite_MEM.
REQ-016 An access SHALL be illegal when memRead_MEM & memWrite_MEM, or when ALU_result_MEM[0]=1.
REQ-017 IDLE with a legal access SHALL drive stall=1 combinationally in the same cycle.
  - Latch the address into mem_addr and st_value_MEM into mem_wdata.
  - Set mem_rd=memRead_MEM and mem_wr=memWrite_MEM at the clock edge.
  - Clear the timeout counter and go to BUSY.
REQ-018 IDLE with an illegal access SHALL drive stall=1 for that cycle, set err, issue no memory request, and go to DONE.
REQ-019 IDLE with no access SHALL drive stall=0 and remain in IDLE.
REQ-020 BUSY SHALL drive stall=1 and hold mem_rd, mem_wr, mem_addr and mem_wdata stable.
REQ-021 BUSY with mem_done=1 SHALL take the following actions at the clock edge:
  - If mem_rd=1, capture mem_rdata into readData_MEM; a store leaves readData_MEM unchanged.
  - Clear mem_rd and mem_wr.
  - Go to DONE.
REQ-022 A 4-bit counter SHALL count BUSY cycles without mem_done.
REQ-023 On the 16th consecutive BUSY cycle without mem_done, the block SHALL time out:
  - Set err and load readData_MEM=16'h0000.
  - Clear mem_rd and mem_wr.
  - Go to DONE.
REQ-024 DONE SHALL drive stall=0 for exactly one cycle, issue no request even if memRead_MEM or memWrite_MEM is still asserted, and return to IDLE. This lets the completed instruction leave EX/MEM without re-issue.
REQ-025 mem_done SHALL be ignored in IDLE and DONE.
REQ-026 Access latency SHALL follow these rules:
  - With mem_done in the first BUSY cycle, stall SHALL be high for 2 cycles and readData_MEM valid in the 3rd cycle (DONE).
  - In general, stall SHALL be high for N+1 cycles, where N is the number of BUSY cycles.
REQ-027 Once set, err SHALL remain set until reset.
REQ-028 Back-to-back accesses SHALL be supported: DONE followed by IDLE SHALL accept a new access in the IDLE cycle.

Reset
REQ-029 Asserting rst (low) SHALL immediately force all state and outputs to their reset values, including mid-BUSY:
  - State IDLE; counter 0; err=0.
  - mem_rd=0, mem_wr=0, mem_addr=16'h0000, mem_wdata=16'h0000, readData_MEM=16'h0000.
REQ-030 During reset, stall SHALL be 0.
REQ-031 The first access after reset deassertion SHALL behave per REQ-017.

Verification
REQ-032 Load: memRead_MEM=1, addr=16'h0010, mem_done=1 in first BUSY cycle with mem_rdata=16'hBEEF -> stall=1,1,0; mem_rd high 1 cycle, mem_addr=16'h0010; readData_MEM=16'hBEEF in DONE.
REQ-033 Store with latency 3: memWrite_MEM=1, addr=16'h0020, st_value=16'h1234, mem_done on 3rd BUSY cycle -> mem_wr=1 and mem_wdata=16'h1234 held 3 cycles; stall high 4 cycles; readData_MEM unchanged.
REQ-034 Misaligned load at addr=16'h0011 -> mem_rd never asserted; stall=1 for one cycle; err=1 and stays 1.
REQ-035 Timeout: load with mem_done never asserted -> stall high 17 cycles; then DONE with readData_MEM=16'h0000 and err=1.
REQ-036 Reset mid-BUSY: drive rst low in the 2nd BUSY cycle -> mem_rd=0 and stall=0 immediately; after release, a new load to 16'h0004 completes per REQ-032.
